// File: rtl/multicycle_cpu_if.sv
// Program/observation bundle for multicycle_cpu.
//   slave  : CPU side. It takes run and the ROM/register/RAM images, and drives the check outputs.
//   master : harness side. It drives run and the images, and observes the check outputs.
// Signals:
//   run                      stall control (low holds the FSM in FETCH)
//   initial_instructions     instruction ROM contents, read continuously
//   initial_register_values  register file image, loaded while reset is asserted
//   initial_memory_values    data RAM image, loaded while reset is asserted
//   pc_check, state_check    current PC and FSM state
//   retire, halted, illegal  status
//   register_check           register file contents
//   memory_check             data RAM contents
//   cycle_count, instret     performance counters
interface multicycle_cpu_if #(
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned DMEM_WORDS = 32
);
  logic        run;
  logic [31:0] initial_instructions    [IMEM_WORDS];
  logic [31:0] initial_register_values [32];
  logic [31:0] initial_memory_values   [DMEM_WORDS];
  logic [31:0] pc_check;
  logic [2:0]  state_check;
  logic        retire;
  logic        halted;
  logic        illegal;
  logic [31:0] register_check [32];
  logic [31:0] memory_check   [DMEM_WORDS];
  logic [31:0] cycle_count;
  logic [31:0] instret;

  modport slave (
    input  run, initial_instructions, initial_register_values, initial_memory_values,
    output pc_check, state_check, retire, halted, illegal, register_check, memory_check,
           cycle_count, instret
  );

  modport master (
    output run, initial_instructions, initial_register_values, initial_memory_values,
    input  pc_check, state_check, retire, halted, illegal, register_check, memory_check,
           cycle_count, instret
  );
endinterface

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I-subset core. Each instruction is sequenced through
// FETCH/DECODE/EXECUTE/MEM/WB, and execution stops in HALT on ebreak or on an unsupported encoding.
// Ports: clk, reset_n (asynchronous, active-low), io (multicycle_cpu_if.slave).
// Optional feature: define MULTICYCLE_CPU_PERF_COUNTERS_EN to build the cycle and instret
// counters. Without it, both outputs are tied to zero.
module multicycle_cpu #(
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned DMEM_WORDS = 32,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic             clk,
  input logic             reset_n,
  multicycle_cpu_if.slave io
);
  localparam int unsigned ImemAw = $clog2(IMEM_WORDS);
  localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [2:0] {
    StFetch = 3'd0, StDecode = 3'd1, StExecute = 3'd2, StMem = 3'd3, StWb = 3'd4, StHalt = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd, AluPassB
  } alu_fn_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic        illegal_q, illegal_d, retire_q, retire_d;
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_r, is_i, is_lui, is_load, is_store, is_jal, is_branch, is_ebreak, legal;
  always_comb begin
    is_r      = (opcode == OpR) &&
                ((funct7 == 7'b0000000) ||
                 (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
    is_i      = (opcode == OpI) &&
                ((funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                 (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1);
    is_lui    = (opcode == OpLui);
    is_load   = (opcode == OpLoad) && (funct3 == 3'b010);
    is_store  = (opcode == OpStore) && (funct3 == 3'b010);
    is_jal    = (opcode == OpJal);
    is_branch = (opcode == OpBranch) && (funct3[2:1] == 2'b00);
    is_ebreak = (ir_q == 32'h0010_0073);
    legal     = is_r | is_i | is_lui | is_load | is_store | is_jal | is_branch;
  end

  // Operand selection for the shared ALU. This also supplies the PC target for jal and for a taken branch.
  logic [31:0] alu_a, alu_b, alu_y;
  alu_fn_e     alu_fn;
  always_comb begin
    alu_a = a_q;
    alu_b = is_r ? b_q : imm_q;
    unique case (funct3)
      3'b000:  alu_fn = (is_r && funct7[5]) ? AluSub : AluAdd;
      3'b001:  alu_fn = AluSll;
      3'b010:  alu_fn = AluSlt;
      3'b011:  alu_fn = AluSltu;
      3'b100:  alu_fn = AluXor;
      3'b101:  alu_fn = funct7[5] ? AluSra : AluSrl;
      3'b110:  alu_fn = AluOr;
      default: alu_fn = AluAnd;
    endcase
    if (is_lui) begin
      alu_fn = AluPassB;
    end else if (is_load || is_store) begin
      alu_fn = AluAdd;
    end else if (is_branch || is_jal) begin
      alu_a  = pc_q;
      alu_fn = AluAdd;
    end
  end

  always_comb begin
    unique case (alu_fn)
      AluAdd:  alu_y = alu_a + alu_b;
      AluSub:  alu_y = alu_a - alu_b;
      AluSll:  alu_y = alu_a << alu_b[4:0];
      AluSlt:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      AluSltu: alu_y = {31'b0, alu_a < alu_b};
      AluXor:  alu_y = alu_a ^ alu_b;
      AluSrl:  alu_y = alu_a >> alu_b[4:0];
      AluSra:  alu_y = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      AluOr:   alu_y = alu_a | alu_b;
      AluAnd:  alu_y = alu_a & alu_b;
      default: alu_y = alu_b;
    endcase
  end

  logic [31:0] pc_plus4, rf_wdata;
  logic        rf_we, dm_we, taken;
  assign pc_plus4 = pc_q + 32'd4;
  assign taken    = funct3[0] ? (a_q != b_q) : (a_q == b_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    retire_d  = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = alu_out_q;
    dm_we     = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (io.run) begin
          ir_d    = io.initial_instructions[pc_q[ImemAw+1:2]];
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d = regs_q[rs1];
        b_d = regs_q[rs2];
        if (is_store)       imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        else if (is_branch) imm_d = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                     ir_q[11:8], 1'b0};
        else if (is_jal)    imm_d = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                                     ir_q[30:21], 1'b0};
        else if (is_lui)    imm_d = {ir_q[31:12], 12'b0};
        else                imm_d = {{20{ir_q[31]}}, ir_q[31:20]};
        if (is_ebreak) begin
          state_d   = StHalt;
          illegal_d = 1'b0;
        end else if (!legal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (is_branch) begin
          pc_d     = taken ? alu_y : pc_plus4;
          retire_d = 1'b1;
          state_d  = StFetch;
        end else if (is_jal) begin
          rf_we    = (rd != 5'd0);
          rf_wdata = pc_plus4;
          pc_d     = alu_y;
          retire_d = 1'b1;
          state_d  = StFetch;
        end else begin
          alu_out_d = alu_y;
          state_d   = (is_load || is_store) ? StMem : StWb;
        end
      end
      StMem: begin
        if (is_store) begin
          dm_we    = 1'b1;
          pc_d     = pc_plus4;
          retire_d = 1'b1;
          state_d  = StFetch;
        end else begin
          mdr_d   = dmem_q[alu_out_q[DmemAw+1:2]];
          state_d = StWb;
        end
      end
      StWb: begin
        rf_we    = (rd != 5'd0);
        rf_wdata = is_load ? mdr_q : alu_out_q;
        pc_d     = pc_plus4;
        retire_d = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StHalt;
    endcase
  end

  // The register and RAM images reload asynchronously, so a reset aborts any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
      retire_q  <= 1'b0;
      regs_q[0] <= '0;
      for (int i = 1; i < 32; i++) regs_q[i] <= io.initial_register_values[i];
      for (int i = 0; i < int'(DMEM_WORDS); i++) dmem_q[i] <= io.initial_memory_values[i];
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
      retire_q  <= retire_d;
      if (rf_we) regs_q[rd] <= rf_wdata;
      if (dm_we) dmem_q[alu_out_q[DmemAw+1:2]] <= b_q;
    end
  end

`ifdef MULTICYCLE_CPU_PERF_COUNTERS_EN
  logic [31:0] cycle_q, instret_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != StHalt) cycle_q <= cycle_q + 32'd1;
      if (retire_q) instret_q <= instret_q + 32'd1;
    end
  end
  assign io.cycle_count = cycle_q;
  assign io.instret     = instret_q;
`else
  assign io.cycle_count = '0;
  assign io.instret     = '0;
`endif

  assign io.pc_check       = pc_q;
  assign io.state_check    = state_q;
  assign io.retire         = retire_q;
  assign io.halted         = (state_q == StHalt);
  assign io.illegal        = (state_q == StHalt) && illegal_q;
  assign io.register_check = regs_q;
  assign io.memory_check   = dmem_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu. A table of short programs, each with hand-computed final
// state, is followed by hand-written sequences for retire timing, stall, reset mid-op and the
// performance counters.
module tb_multicycle_cpu;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  multicycle_cpu_if #(.IMEM_WORDS(32), .DMEM_WORDS(32)) bus ();

  multicycle_cpu #(.IMEM_WORDS(32), .DMEM_WORDS(32), .RESET_PC(32'h0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] i0, i1, i2;
    logic [31:0] r1, r2;
    int unsigned cycles;
    int unsigned ra;
    logic [31:0] va;
    int unsigned rb;
    logic [31:0] vb;
    logic [31:0] pc;
    logic        hlt;
    logic        ill;
    logic [31:0] m1;
  } vec_t;

  vec_t vecs [13];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Load a program and images, then pulse reset. On return, reset has just been released on a
  // falling edge, so the next rising edge performs the first fetch.
  task automatic load(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                      input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] m1);
    for (int i = 0; i < 32; i++) begin
      bus.initial_instructions[i]    = Ebreak;
      bus.initial_register_values[i] = 32'h0;
      bus.initial_memory_values[i]   = 32'h0;
    end
    bus.initial_instructions[0]    = i0;
    bus.initial_instructions[1]    = i1;
    bus.initial_instructions[2]    = i2;
    bus.initial_register_values[0] = 32'hFFFF_FFFF;
    bus.initial_register_values[1] = r1;
    bus.initial_register_values[2] = r2;
    bus.initial_memory_values[1]   = m1;
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    bus.run = 1'b1;

    //            i0            i1            i2      r1            r2            cyc ra va
    //            rb vb          pc     hlt   ill   m1
    vecs[0]  = '{32'h00500093, 32'hFFD08113, Ebreak, 32'h0, 32'h0, 14, 1, 32'd5,
                 2, 32'd2, 32'd8, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{32'h00208463, Ebreak, Ebreak, 32'd5, 32'd5, 3, 1, 32'd5,
                 2, 32'd5, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{32'h00208463, Ebreak, Ebreak, 32'd5, 32'd6, 3, 1, 32'd5,
                 2, 32'd6, 32'd4, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{32'h00209463, Ebreak, Ebreak, 32'd5, 32'd6, 3, 1, 32'd5,
                 2, 32'd6, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{32'h008000EF, Ebreak, Ebreak, 32'h0, 32'h0, 3, 1, 32'd4,
                 2, 32'd0, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{32'h0000007F, Ebreak, Ebreak, 32'd5, 32'd6, 5, 1, 32'd5,
                 2, 32'd6, 32'd0, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{32'h402081B3, Ebreak, Ebreak, 32'd5, 32'd6, 4, 3, 32'hFFFF_FFFF,
                 2, 32'd6, 32'd4, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{32'h0020B1B3, 32'h0020A233, Ebreak, 32'hFFFF_FFFF, 32'd1, 8, 3, 32'd0,
                 4, 32'd1, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{32'h4020D1B3, 32'h0020D233, Ebreak, 32'h8000_0000, 32'h24, 8, 3, 32'hF800_0000,
                 4, 32'h0800_0000, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{32'h123452B7, 32'h00700013, Ebreak, 32'h0, 32'h0, 8, 5, 32'h1234_5000,
                 0, 32'd0, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{32'h402091B3, Ebreak, Ebreak, 32'h0, 32'h0, 5, 3, 32'd0,
                 0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0};
    vecs[11] = '{32'h00102223, 32'h00402183, Ebreak, 32'hDEAD_BEEF, 32'h0, 9, 3, 32'hDEAD_BEEF,
                 1, 32'hDEAD_BEEF, 32'd8, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[12] = '{32'hFFF0C193, 32'h40415213, Ebreak, 32'h0F0F_0F0F, 32'h8000_0000, 8, 3,
                 32'hF0F0_F0F0, 4, 32'hF800_0000, 32'd8, 1'b0, 1'b0, 32'h0};

    // Reset state
    load(Ebreak, Ebreak, Ebreak, 32'd7, 32'd9, 32'h0);
    check32("reset pc", bus.pc_check, 32'h0);
    check32("reset state", {29'b0, bus.state_check}, 32'd0);
    check32("reset retire", {31'b0, bus.retire}, 32'd0);
    check32("reset halted", {31'b0, bus.halted}, 32'd0);
    check32("reset x0", bus.register_check[0], 32'h0);
    check32("reset x1", bus.register_check[1], 32'd7);

    for (int k = 0; k < 13; k++) begin
      load(vecs[k].i0, vecs[k].i1, vecs[k].i2, vecs[k].r1, vecs[k].r2, 32'h0);
      step(int'(vecs[k].cycles));
      check32($sformatf("v%0d x%0d", k, vecs[k].ra), bus.register_check[vecs[k].ra], vecs[k].va);
      check32($sformatf("v%0d x%0d", k, vecs[k].rb), bus.register_check[vecs[k].rb], vecs[k].vb);
      check32($sformatf("v%0d pc", k), bus.pc_check, vecs[k].pc);
      check32($sformatf("v%0d halted", k), {31'b0, bus.halted}, {31'b0, vecs[k].hlt});
      check32($sformatf("v%0d illegal", k), {31'b0, bus.illegal}, {31'b0, vecs[k].ill});
      check32($sformatf("v%0d mem1", k), bus.memory_check[1], vecs[k].m1);
    end

    // jal: retire pulses only on the third edge, as the FSM re-enters FETCH
    load(32'h008000EF, Ebreak, Ebreak, 32'h0, 32'h0, 32'h0);
    step(1);
    check32("jal retire c1", {31'b0, bus.retire}, 32'd0);
    step(1);
    check32("jal retire c2", {31'b0, bus.retire}, 32'd0);
    check32("jal state c2", {29'b0, bus.state_check}, 32'd2);
    step(1);
    check32("jal retire c3", {31'b0, bus.retire}, 32'd1);
    check32("jal state c3", {29'b0, bus.state_check}, 32'd0);
    step(1);
    check32("jal retire c4", {31'b0, bus.retire}, 32'd0);

    // Stall: run low holds the FSM in FETCH with the PC frozen
    bus.run = 1'b0;
    load(32'h00500093, Ebreak, Ebreak, 32'h0, 32'h0, 32'h0);
    step(5);
    check32("stall state", {29'b0, bus.state_check}, 32'd0);
    check32("stall pc", bus.pc_check, 32'h0);
    check32("stall x1", bus.register_check[1], 32'h0);
    bus.run = 1'b1;
    step(1);
    check32("unstall state", {29'b0, bus.state_check}, 32'd1);

    // Reset while a sw is in MEM: asynchronous restore, no write
    load(32'h00102223, Ebreak, Ebreak, 32'hDEAD_BEEF, 32'h0, 32'h1111_1111);
    step(3);
    check32("sw in mem", {29'b0, bus.state_check}, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check32("midop mem1", bus.memory_check[1], 32'h1111_1111);
    check32("midop pc", bus.pc_check, 32'h0);
    check32("midop state", {29'b0, bus.state_check}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Counters over the addi/addi/ebreak program: 4+4+2 active cycles, two retirements
    load(32'h00500093, 32'hFFD08113, Ebreak, 32'h0, 32'h0, 32'h0);
    step(14);
`ifdef MULTICYCLE_CPU_PERF_COUNTERS_EN
    check32("cycle_count", bus.cycle_count, 32'd10);
    check32("instret", bus.instret, 32'd2);
`else
    check32("cycle_count", bus.cycle_count, 32'd0);
    check32("instret", bus.instret, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
